fb_slave_regs: RTL and testbench

FlexBus-style multiplexed address/data slave that answers MCU-initiated read and write cycles on the PL side of the PS–PL link. It holds a bank of NREG 32-bit control registers that the MCU writes and the fabric reads. It also exposes NREG 32-bit status words that the fabric drives and the MCU reads. Bus inputs arrive already synchronised to CLK, and every bus output is registered.

---
 rtl/fb_slave_regs.sv | 138 +++++++++++++
 tb/tb_fb_slave_regs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_slave_regs.sv
// FlexBus-style multiplexed address/data slave: NREG read/write control registers
// and NREG read-only status words, with a fixed wait-state count before acknowledge.
module fb_slave_regs #(
    parameter int NREG     = 4,
    parameter int AW       = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               fb_csn,
    input  logic               fb_ale,
    input  logic               fb_rwn,
    input  logic [31:0]        fb_ad_i,
    output logic [31:0]        fb_ad_o,
    output logic               fb_ad_oe,
    output logic               fb_tan,
    output logic [NREG*32-1:0] ctrl_q,
    input  logic [NREG*32-1:0] sts_i,
    output logic [NREG-1:0]    wr_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    state_t         state_reg;
    logic [3:0]     cnt_reg;
    logic [AW-1:0]  addr_reg;
    logic           rwn_reg;
    logic [31:0]    rd_data_reg;
    logic           oe_reg;
    logic           tan_reg;

    logic [AW-1:0]  addr_in;
    logic [31:0]    rd_mux;
    logic           start;
    logic           wr_commit;

    assign addr_in   = fb_ad_i[AW+1:2];
    assign start     = !fb_csn && fb_ale;
    // The write lands on the ACK edge even if CSn rises there.
    assign wr_commit = (state_reg == S_ACK) && !rwn_reg;

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NREG; k++) begin
            if (addr_in == AW'(k))
                rd_mux = ctrl_q[32*k +: 32];
            if (addr_in == AW'(k + NREG))
                rd_mux = sts_i[32*k +: 32];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            rwn_reg     <= 1'b1;
            rd_data_reg <= '0;
            oe_reg      <= 1'b0;
            tan_reg     <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        addr_reg <= addr_in;
                        rwn_reg  <= fb_rwn;
                        cnt_reg  <= 4'(WAIT_CYC);
                        oe_reg   <= fb_rwn;
                        if (fb_rwn)
                            rd_data_reg <= rd_mux;
                        if (WAIT_CYC == 0) begin
                            state_reg <= S_ACK;
                            tan_reg   <= 1'b0;
                        end else begin
                            state_reg <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (fb_csn) begin
                        state_reg <= S_IDLE;
                        oe_reg    <= 1'b0;
                    end else if (cnt_reg == 4'd1) begin
                        state_reg <= S_ACK;
                        tan_reg   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                S_ACK: begin
                    tan_reg   <= 1'b1;
                    oe_reg    <= 1'b0;
                    state_reg <= fb_csn ? S_IDLE : S_DONE;
                end
                S_DONE: begin
                    if (fb_csn)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_ctrl
            logic [31:0] q_reg;
            logic        pulse_reg;
            logic        hit;

            assign hit = wr_commit && (addr_reg == AW'(gi));

            always_ff @(posedge CLK) begin
                if (RST) begin
                    q_reg     <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    if (hit)
                        q_reg <= fb_ad_i;
                end
            end

            assign ctrl_q[32*gi +: 32] = q_reg;
            assign wr_pulse[gi]        = pulse_reg;
        end
    endgenerate

    assign fb_ad_o  = rd_data_reg;
    assign fb_ad_oe = oe_reg;
    assign fb_tan   = tan_reg;

endmodule

// File: tb/tb_fb_slave_regs.sv
// Drives two slaves (WAIT_CYC=2 and WAIT_CYC=0) with the same bus traffic and
// checks acknowledges and write strobes against a queue of predicted responses.
module tb_fb_slave_regs;

    localparam int NREG = 4;
    localparam int AW   = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         fb_csn;
    logic         fb_ale;
    logic         fb_rwn;
    logic [31:0]  fb_ad_i;
    logic [127:0] sts_i;

    logic [31:0]  ad_o [2];
    logic         oe   [2];
    logic         tan  [2];
    logic [127:0] ctrl [2];
    logic [3:0]   wrp  [2];

    fb_slave_regs #(.NREG(NREG), .AW(AW), .WAIT_CYC(2)) u_w2 (
        .CLK(CLK), .RST(RST), .fb_csn(fb_csn), .fb_ale(fb_ale), .fb_rwn(fb_rwn),
        .fb_ad_i(fb_ad_i), .fb_ad_o(ad_o[0]), .fb_ad_oe(oe[0]), .fb_tan(tan[0]),
        .ctrl_q(ctrl[0]), .sts_i(sts_i), .wr_pulse(wrp[0])
    );

    fb_slave_regs #(.NREG(NREG), .AW(AW), .WAIT_CYC(0)) u_w0 (
        .CLK(CLK), .RST(RST), .fb_csn(fb_csn), .fb_ale(fb_ale), .fb_rwn(fb_rwn),
        .fb_ad_i(fb_ad_i), .fb_ad_o(ad_o[1]), .fb_ad_oe(oe[1]), .fb_tan(tan[1]),
        .ctrl_q(ctrl[1]), .sts_i(sts_i), .wr_pulse(wrp[1])
    );

    always #5 CLK = ~CLK;

    int ecnt = 0;
    always @(posedge CLK) ecnt <= ecnt + 1;

    typedef struct {
        int          dut;
        int          at;
        bit          rd;
        logic [31:0] data;
    } ack_t;

    typedef struct {
        int           dut;
        int           at;
        int           idx;
        logic [127:0] snap;
    } wr_t;

    ack_t        ackq [$];
    wr_t         wrq  [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl   [2][4];
    logic [31:0] sts_v [4];

    function automatic int wcyc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [127:0] pack_mdl(input int d);
        logic [127:0] p;
        for (int k = 0; k < NREG; k++) p[32*k +: 32] = mdl[d][k];
        return p;
    endfunction

    function automatic logic [127:0] pack_sts();
        logic [127:0] p;
        for (int k = 0; k < NREG; k++) p[32*k +: 32] = sts_v[k];
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every acknowledge and every write strobe must match the oldest
    // pending prediction for that slave, including the cycle it appears in.
    always @(negedge CLK) begin
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (tan[d] === 1'b0) begin
                idx = -1;
                for (int i = 0; i < ackq.size(); i++)
                    if (ackq[i].dut == d) begin idx = i; break; end
                if (idx < 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ack dut%0d: got fb_tan=0 required 1", d);
                end else begin
                    check($sformatf("ack_cycle_dut%0d", d), ecnt, ackq[idx].at);
                    check($sformatf("ack_oe_dut%0d", d), oe[d], ackq[idx].rd);
                    if (ackq[idx].rd)
                        check($sformatf("rd_data_dut%0d", d), ad_o[d], ackq[idx].data);
                    $display("cyc %0d dut%0d ack %s data=%h", ecnt, d,
                             ackq[idx].rd ? "rd" : "wr", ad_o[d]);
                    ackq.delete(idx);
                end
            end
            if ((|wrp[d]) === 1'b1) begin
                idx = -1;
                for (int i = 0; i < wrq.size(); i++)
                    if (wrq[i].dut == d) begin idx = i; break; end
                if (idx < 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_wr_pulse dut%0d: got %b required 0000", d, wrp[d]);
                end else begin
                    check($sformatf("wr_cycle_dut%0d", d), ecnt, wrq[idx].at);
                    check($sformatf("wr_pulse_dut%0d", d), wrp[d], 128'(1) << wrq[idx].idx);
                    check($sformatf("ctrl_q_dut%0d", d), ctrl[d], wrq[idx].snap);
                    $display("cyc %0d dut%0d wr_pulse=%b ctrl=%h", ecnt, d, wrp[d], ctrl[d]);
                    wrq.delete(idx);
                end
            end
        end
    end

    // One bus transfer. r = relative edge at which CSn=1 is first sampled
    // (edge 0 samples the start); rst_edge = first of two reset edges, 0 = none.
    task automatic xfer(input bit rd, input int a, input logic [31:0] wdata,
                        input int r, input int rst_edge);
        int          c;
        int          w;
        bit          ack;
        bit          wr;
        logic [31:0] rdat;
        logic [31:0] adr;
        c = ecnt;
        for (int d = 0; d < 2; d++) begin
            w    = wcyc(d);
            ack  = (r > w) && (rst_edge == 0 || rst_edge > w);
            wr   = ack && !rd && (a < NREG) && (rst_edge == 0 || rst_edge > w + 1);
            rdat = (a < NREG) ? mdl[d][a] : (a < 2*NREG) ? sts_v[a-NREG] : 32'h0;
            if (ack) ackq.push_back('{d, c + 1 + w, rd, rdat});
            if (wr) begin
                mdl[d][a] = wdata;
                wrq.push_back('{d, c + 2 + w, a, pack_mdl(d)});
            end
        end
        if (rst_edge != 0)
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < NREG; k++) mdl[d][k] = 32'h0;

        adr       = $urandom();
        adr[5:2]  = a[3:0];
        fb_csn    = 1'b0;
        fb_ale    = 1'b1;
        fb_rwn    = rd;
        fb_ad_i   = adr;
        tick();
        fb_ale    = 1'b0;
        fb_ad_i   = wdata;
        for (int k = 0; k < NREG; k++) sts_v[k] = $urandom();
        sts_i     = pack_sts();
        for (int j = 1; j <= r; j++) begin
            fb_csn = (j == r);
            RST    = (rst_edge != 0) && (j >= rst_edge) && (j <= rst_edge + 1);
            fb_ale = !fb_csn && ($urandom_range(0, 2) == 0);
            tick();
        end
        fb_ale = 1'b0;
        RST    = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            fb_ale  = $urandom_range(0, 1);
            fb_ad_i = $urandom();
            tick();
        end
        fb_ale = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag, input bit ctrl_zero);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_tan_dut%0d", tag, d), tan[d], 1'b1);
            check($sformatf("%s_oe_dut%0d", tag, d), oe[d], 1'b0);
            check($sformatf("%s_wrp_dut%0d", tag, d), wrp[d], 4'b0);
            if (ctrl_zero) check($sformatf("%s_ctrl_dut%0d", tag, d), ctrl[d], 128'h0);
        end
    endtask

    initial begin
        int r;
        RST     = 1'b1;
        fb_csn  = 1'b1;
        fb_ale  = 1'b0;
        fb_rwn  = 1'b1;
        fb_ad_i = '0;
        for (int k = 0; k < NREG; k++) begin
            sts_v[k]  = 32'h0;
            mdl[0][k] = 32'h0;
            mdl[1][k] = 32'h0;
        end
        sts_i = pack_sts();
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check_idle_outputs("reset", 1'b1);
        for (int d = 0; d < 2; d++) check($sformatf("reset_ad_o_dut%0d", d), ad_o[d], 32'h0);

        xfer(1'b0, 3, 32'hDEAD_BEEF, 4, 0);
        xfer(1'b0, 0, 32'h1234_5678, 3, 1);
        check_idle_outputs("midwait_reset", 1'b1);

        xfer(1'b0, 1, 32'hA5A5_0F0F, 4, 0);
        xfer(1'b1, 1, $urandom(), 4, 0);

        sts_v[2] = 32'hCAFE_0002;
        sts_i    = pack_sts();
        xfer(1'b1, 6, $urandom(), 4, 0);
        xfer(1'b0, 6, 32'hFFFF_FFFF, 4, 0);
        xfer(1'b1, 9, $urandom(), 4, 0);

        xfer(1'b0, 3, 32'h0BAD_0003, 4, 0);
        xfer(1'b0, 3, 32'h3333_3333, 1, 0);
        xfer(1'b0, 3, 32'h4444_4444, 4, 0);
        xfer(1'b1, 3, $urandom(), 4, 0);
        xfer(1'b0, 2, 32'h2222_2222, 4, 0);

        for (int n = 0; n < 200; n++) begin
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 4;
            xfer($urandom_range(0, 1), $urandom_range(0, 15), $urandom(), r, 0);
        end

        repeat (4) tick();
        for (int d = 0; d < 2; d++) check($sformatf("final_ctrl_dut%0d", d), ctrl[d], pack_mdl(d));
        check("pending_acks", ackq.size(), 0);
        check("pending_writes", wrq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
